// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches sequential words into a DEPTH-entry queue; redirect flushes and restarts.
// Optional feature: define IFETCH_MISALIGN_CHK_EN to fault and halt on misaligned redirect targets.
module ifetch_queue #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
`ifdef IFETCH_MISALIGN_CHK_EN
    localparam logic [1:0] ST_HALT  = 2'd3;
`endif

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fault_q, fault_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic          push;
    logic          pop;
    logic          misaligned;
    logic [31:0]   target_pc;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign target_pc  = redirect_pc;
`else
    assign misaligned = 1'b0;
    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

    // A redirect kills the request combinationally so its ack can never be pushed.
    assign imem_req    = !reset && !redirect && (state_q == ST_FILL);
    assign imem_addr   = fetch_pc_q;
    assign push        = imem_req && imem_ack;
    assign inst_valid  = (count_q != '0);
    assign pop         = inst_valid && inst_ready && !redirect;
    assign inst_data   = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign inst_pc     = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;
    assign fetch_fault = fault_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fault_d    = fault_q;

        if (redirect) begin
            fetch_pc_d = target_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
`ifdef IFETCH_MISALIGN_CHK_EN
            fault_d = misaligned;
            state_d = misaligned ? ST_HALT : ST_FLUSH;
`else
            fault_d = 1'b0;
            state_d = ST_FLUSH;
`endif
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            case (state_q)
                ST_FILL:  if (push && !pop && count_q == LAST_SLOT) state_d = ST_FULL;
                ST_FULL:  if (pop) state_d = ST_FILL;
                ST_FLUSH: state_d = ST_FILL;
`ifdef IFETCH_MISALIGN_CHK_EN
                ST_HALT:  state_d = ST_HALT;
`endif
                default:  state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_FILL;
            fetch_pc_q <= RESET_VECTOR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    // NOTE: queue storage has no reset; count_q gates every read, so stale entries are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            data_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    logic unused_ok;
    assign unused_ok = misaligned;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, fill/full, redirect, address wrap and misaligned-redirect handling.
module tb_ifetch_queue;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int tests_run    = 0;
    int tests_failed = 0;

    ifetch_queue #(.DEPTH(4), .RESET_VECTOR(32'h0000_0000)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge and clear the one-cycle pulses.
    task automatic step();
        @(posedge CLK);
        #1;
        imem_ack = 1'b0;
        redirect = 1'b0;
    endtask

    // Memory model: answers a pending request this cycle with pc ^ K.
    task automatic mem_resp(input logic en);
        #1;
        imem_ack   = en && imem_req;
        imem_rdata = imem_addr ^ K;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        redirect = 1'b1;
        #1;
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        tests_run++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_head: data %h pc %h want 0 0", inst_data, inst_pc); end
        tests_run++; if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        step();
        reset = 1'b0; inst_ready = 1'b0;
        mem_resp(1'b1);
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL first_req: req %b addr %h want 1 00000000", imem_req, imem_addr); end
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL no_bypass: got %b want 0", inst_valid); end
        step();
        mem_resp(1'b1);
        tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'hA5A5_0000) begin tests_failed++; $display("FAIL first_valid: v %b pc %h data %h want 1 00000000 a5a50000", inst_valid, inst_pc, inst_data); end
        tests_run++; if (imem_addr !== 32'h4) begin tests_failed++; $display("FAIL second_addr: got %h want 00000004", imem_addr); end
        step();
    endtask

    task automatic test_full();
        mem_resp(1'b1);
        tests_run++; if (imem_addr !== 32'h8) begin tests_failed++; $display("FAIL third_addr: got %h want 00000008", imem_addr); end
        step();
        mem_resp(1'b1);
        tests_run++; if (imem_addr !== 32'hC) begin tests_failed++; $display("FAIL fourth_addr: got %h want 0000000c", imem_addr); end
        step();
        mem_resp(1'b1);
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL full_req: got %b want 0", imem_req); end
        tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin tests_failed++; $display("FAIL full_head: v %b pc %h want 1 00000000", inst_valid, inst_pc); end
        step();
        inst_ready = 1'b1;
        mem_resp(1'b1);
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL full_hold: got %b want 0", imem_req); end
        step();
        inst_ready = 1'b0;
        mem_resp(1'b0);
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin tests_failed++; $display("FAIL refill: req %b addr %h want 1 00000010", imem_req, imem_addr); end
        tests_run++; if (inst_pc !== 32'h4 || inst_data !== 32'hA5A5_0004) begin tests_failed++; $display("FAIL after_pop: pc %h data %h want 00000004 a5a50004", inst_pc, inst_data); end
        inst_ready = 1'b1;
        mem_resp(1'b1);
        step();
        inst_ready = 1'b0;
        #1;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin tests_failed++; $display("FAIL push_pop_req: req %b addr %h want 1 00000014", imem_req, imem_addr); end
        tests_run++; if (inst_pc !== 32'h8) begin tests_failed++; $display("FAIL push_pop_head: pc %h want 00000008", inst_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_resp(1'b1);
            step();
        end
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL redir_drop_req: got %b want 0", imem_req); end
        tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin tests_failed++; $display("FAIL redir_pre_head: v %b pc %h want 1 00000000", inst_valid, inst_pc); end
        step();
        inst_ready = 1'b1;
        #1;
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush: got %b want 0", inst_valid); end
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL redir_bubble: got %b want 0", imem_req); end
        step();
        inst_ready = 1'b0;
        mem_resp(1'b1);
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin tests_failed++; $display("FAIL redir_addr: req %b addr %h want 1 00000100", imem_req, imem_addr); end
        step();
        #1;
        tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'hA5A5_0100) begin tests_failed++; $display("FAIL redir_head: v %b pc %h data %h want 1 00000100 a5a50100", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'h500;
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        #1;
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL flush_redir_req: got %b want 0", imem_req); end
        step();
        #1;
        tests_run++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_bubble: req %b v %b want 0 0", imem_req, inst_valid); end
        step();
        mem_resp(1'b1);
        tests_run++; if (imem_addr !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL wrap_addr0: got %h want fffffff8", imem_addr); end
        step();
        mem_resp(1'b1);
        tests_run++; if (imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr1: got %h want fffffffc", imem_addr); end
        step();
        mem_resp(1'b1);
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr2: got %h want 00000000", imem_addr); end
        step();
        inst_ready = 1'b1;
        #1;
        tests_run++; if (inst_pc !== 32'hFFFF_FFF8 || inst_data !== 32'h5A5A_FFF8) begin tests_failed++; $display("FAIL wrap_pop0: pc %h data %h want fffffff8 5a5afff8", inst_pc, inst_data); end
        step();
        #1;
        tests_run++; if (inst_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pop1: pc %h want fffffffc", inst_pc); end
        step();
        #1;
        tests_run++; if (inst_pc !== 32'h0 || inst_data !== 32'hA5A5_0000) begin tests_failed++; $display("FAIL wrap_pop2: pc %h data %h want 00000000 a5a50000", inst_pc, inst_data); end
        step();
        inst_ready = 1'b0;
        #1;
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_drained: got %b want 0", inst_valid); end
    endtask

    task automatic test_fault();
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        step();
        #1;
`ifdef IFETCH_MISALIGN_CHK_EN
        tests_run++; if (fetch_fault !== 1'b1) begin tests_failed++; $display("FAIL fault_set: got %b want 1", fetch_fault); end
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL halt_req: got %b want 0", imem_req); end
`else
        tests_run++; if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL fault_tied: got %b want 0", fetch_fault); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin tests_failed++; $display("FAIL mask_addr: req %b addr %h want 1 00000100", imem_req, imem_addr); end
`endif
        step();
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        #1;
        tests_run++; if (fetch_fault !== 1'b0 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL fault_clear: fault %b req %b want 0 0", fetch_fault, imem_req); end
        step();
        #1;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin tests_failed++; $display("FAIL resume_addr: req %b addr %h want 1 00000200", imem_req, imem_addr); end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        test_reset();
        test_full();
        test_redirect();
        test_wrap();
        test_fault();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
